// File: rtl/pipe_hazard_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_pkg
// Description : Shared types for the pipeline hazard controller: forwarding
//               select encoding, controller state encoding, default latency
//               field width.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

   // Default width of the multi-cycle latency field (max latency 63)
   localparam int MC_LAT_W_DEFAULT = 6;

   // Operand forwarding source for the execute stage
   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_WB   = 2'b01,
      FWD_MEM  = 2'b10
   } forward_t;

   // Multi-cycle unit occupancy state
   typedef enum logic {
      HZ_IDLE    = 1'b0,
      HZ_MC_BUSY = 1'b1
   } hz_state_t;

endpackage : pipe_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fwd_select
// Description : Per-operand forwarding select. The MEM-stage result is the
//               youngest, so it wins over WB. Register 0 is hard-wired zero
//               and is never forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_select
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int FWD_EN = 1
)(
   input  logic [REG_AW-1:0] i_rs,
   input  logic [REG_AW-1:0] i_rd_m,
   input  logic              i_reg_write_m,
   input  logic [REG_AW-1:0] i_rd_w,
   input  logic              i_reg_write_w,
   output logic [1:0]        o_fwd
);

   forward_t w_sel;

   generate
      if (FWD_EN != 0) begin : g_fwd_on
         // Pick the youngest in-flight producer of this source register
         always_comb begin
            w_sel = FWD_NONE;
            if ((i_rs != '0) && (i_rs == i_rd_m) && i_reg_write_m) begin
               w_sel = FWD_MEM;
            end else if ((i_rs != '0) && (i_rs == i_rd_w) && i_reg_write_w) begin
               w_sel = FWD_WB;
            end
         end
      end else begin : g_fwd_off
         // Forwarding disabled: operands always come from the register file
         always_comb begin
            w_sel = FWD_NONE;
         end
      end
   endgenerate

   assign o_fwd = w_sel;

endmodule : fwd_select
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Five-stage pipeline hazard controller. Generates operand
//               forwarding selects, load-use stalls, branch flushes, memory
//               wait stalls and multi-cycle (mul/div) execute-stage stalls.
//               The multi-cycle counter runs independently of memory waits.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int MC_LAT_W = MC_LAT_W_DEFAULT,
   parameter int FWD_EN   = 1
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [REG_AW-1:0]   rs1_d,
   input  logic [REG_AW-1:0]   rs2_d,
   input  logic [REG_AW-1:0]   rs1_e,
   input  logic [REG_AW-1:0]   rs2_e,
   input  logic [REG_AW-1:0]   rd_e,
   input  logic [REG_AW-1:0]   rd_m,
   input  logic [REG_AW-1:0]   rd_w,
   input  logic                reg_write_m,
   input  logic                reg_write_w,
   input  logic                load_e,
   input  logic                pc_src_e,
   input  logic                mc_start_e,
   input  logic [MC_LAT_W-1:0] mc_lat,
   input  logic                mem_req_m,
   input  logic                mem_ready_m,
   output logic [1:0]          forward_a_e,
   output logic [1:0]          forward_b_e,
   output logic                stall_f,
   output logic                stall_d,
   output logic                stall_e,
   output logic                stall_m,
   output logic                flush_d,
   output logic                flush_e,
   output logic                flush_m,
   output logic                flush_w,
   output logic                mc_busy
);

   localparam logic [MC_LAT_W-1:0] c_LAT_ONE = MC_LAT_W'(1);
   localparam logic [MC_LAT_W-1:0] c_LAT_TWO = MC_LAT_W'(2);

   hz_state_t           r_state;
   logic [MC_LAT_W-1:0] r_cnt;
   logic                r_mc_busy;

   logic [1:0] w_fwd_a;
   logic [1:0] w_fwd_b;
   logic       w_lu;
   logic       w_mw;
   logic       w_mc_go;
   logic       w_mc_stall;
   logic       w_e_hold;
   logic       w_br_eff;
   logic       w_lu_eff;

   fwd_select #(
      .REG_AW (REG_AW),
      .FWD_EN (FWD_EN)
   ) u_fwd_a (
      .i_rs          (rs1_e),
      .i_rd_m        (rd_m),
      .i_reg_write_m (reg_write_m),
      .i_rd_w        (rd_w),
      .i_reg_write_w (reg_write_w),
      .o_fwd         (w_fwd_a)
   );

   fwd_select #(
      .REG_AW (REG_AW),
      .FWD_EN (FWD_EN)
   ) u_fwd_b (
      .i_rs          (rs2_e),
      .i_rd_m        (rd_m),
      .i_reg_write_m (reg_write_m),
      .i_rd_w        (rd_w),
      .i_reg_write_w (reg_write_w),
      .o_fwd         (w_fwd_b)
   );

   // Load in E whose destination feeds an instruction in D
   assign w_lu = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

   // Memory access in M that has not completed this cycle
   assign w_mw = mem_req_m && !mem_ready_m;

   // A multi-cycle op starts only from IDLE; a start seen while busy is the
   // same op still held in E
   assign w_mc_go    = (r_state == HZ_IDLE) && mc_start_e && (mc_lat >= c_LAT_TWO);
   assign w_mc_stall = w_mc_go || (r_state == HZ_MC_BUSY);

   // E cannot advance: its instruction stays put, so branch and load-use
   // decisions wait until it actually moves on
   assign w_e_hold = w_mw || w_mc_stall;
   assign w_br_eff = pc_src_e && !w_e_hold;
   assign w_lu_eff = w_lu && !pc_src_e && !w_e_hold;

   // Multi-cycle occupancy: counter holds the busy cycles left after this one
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= HZ_IDLE;
         r_cnt     <= '0;
         r_mc_busy <= 1'b0;
      end else begin
         case (r_state)
            HZ_IDLE: begin
               if (w_mc_go) begin
                  r_state   <= HZ_MC_BUSY;
                  r_cnt     <= mc_lat - c_LAT_TWO;
                  r_mc_busy <= 1'b1;
               end
            end
            HZ_MC_BUSY: begin
               if (r_cnt == '0) begin
                  r_state   <= HZ_IDLE;
                  r_mc_busy <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - c_LAT_ONE;
               end
            end
            default: begin
               r_state   <= HZ_IDLE;
               r_cnt     <= '0;
               r_mc_busy <= 1'b0;
            end
         endcase
      end
   end

   // While reset is held every control output is forced quiet
   assign forward_a_e = rst ? w_fwd_a : FWD_NONE;
   assign forward_b_e = rst ? w_fwd_b : FWD_NONE;
   assign stall_f     = rst && (w_e_hold || w_lu_eff);
   assign stall_d     = rst && (w_e_hold || w_lu_eff);
   assign stall_e     = rst && w_e_hold;
   assign stall_m     = rst && w_mw;
   assign flush_d     = rst && w_br_eff;
   assign flush_e     = rst && (w_br_eff || w_lu_eff);
   assign flush_m     = rst && w_mc_stall && !w_mw;
   assign flush_w     = rst && w_mw;
   assign mc_busy     = r_mc_busy;

endmodule : pipe_hazard_ctrl
`default_nettype wire
